gbf_fill_arbiter: RTL
=====================

Name: gbf_fill_arbiter

Overview:
- Request arbiter that sits directly upstream of the chip interface block.
- Watches write/read address pointers of the six global buffers (flag/weight, weight, flag/act, act, flag/ofm, ofm) plus the config request.
- Decides which burst the off-chip port serves next, then issues a one-cycle request carrying the buffer code and direction.
- Tracks the burst word count and re-arbitrates only when the burst completes.

Parameters:
- FLG_AW, 5, address width of FLGWEI/FLGACT/FLGOFM buffers
- DAT_AW, 9, address width of WEI/ACT/OFM buffers
- BURST_LEN, 16, words per granted data burst (power of 2, ≤ 2^FLG_AW/2)
- CFG_LEN, 8, words per config burst

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- Reset  in  1  sync global clear: FSM to IDLE, pending CFG cleared, counter 0
- Reset_WEI / Reset_ACT / Reset_OFM  in  1 each  sync per-class pointer clear indication
- IF_Val  in  1  level; host link enabled, gates all grants
- CFG_Req  in  1  pulse; latches pending config request
- CFG_Val  in  1  config word accepted
- GBFFLGWEI_AddrWr/AddrRd, GBFFLGACT_AddrWr/AddrRd, GBFFLGOFM_AddrWr/AddrRd  in  FLG_AW  pointers
- GBFWEI_AddrWr/AddrRd, GBFACT_AddrWr/AddrRd, GBFOFM_AddrWr/AddrRd  in  DAT_AW  pointers
- GBFFLGWEI_EnWr, GBFWEI_EnWr, GBFFLGACT_EnWr, GBFACT_EnWr  in  1  input-buffer word written
- GBFFLGOFM_EnRd, GBFOFM_EnRd  in  1  output-buffer word read
- IF_Rdy  in  1  interface ready for new request
- IF_Req  out  1  grant pulse
- IF_Cfg  out  4  code: CFG 0, ACT 2, FLGACT 4, WEI 6, FLGWEI 8, FLGOFM 10, OFM 11
- IF_RdWr  out  1  1 = host→chip, 0 = chip→host
- ARB_Busy  out  1  burst in progress

Behaviour:
- Reset: clk with rst_n asynchronous, active-low.
- Output reset values: IF_Req 0, IF_Cfg 0, IF_RdWr 1, ARB_Busy 0. Internal: cfg_pend 0, cnt 0, rr pointer FLGWEI.
- Occupancy per buffer: occ = (AddrWr − AddrRd) mod 2^AW, at the buffer's own width.
  - Input free space = 2^AW − 1 − occ.
  - Input eligible when free ≥ BURST_LEN.
  - Output eligible when occ ≥ BURST_LEN.
- A class is ineligible in the cycle its Reset_X is high and in the following cycle.
- FSM states: IDLE, GRANT, BUSY.
  - IDLE → GRANT when IF_Val && IF_Rdy && (cfg_pend || any eligible). The winner is registered.
  - GRANT: IF_Req=1 for exactly one cycle. IF_Cfg/IF_RdWr take the winner's code and hold until the next grant. ARB_Busy=1. Then → BUSY.
  - BUSY: cnt increments on the winner's strobe (CFG_Val / EnWr / EnRd). Strobes of other classes are ignored.
  - BUSY exit: when cnt == len−1 and the strobe is high → IDLE next cycle; cnt ← 0; ARB_Busy ← 0.
- Burst length: len = CFG_LEN for CFG, BURST_LEN otherwise.
- Priority: cfg_pend > FLGOFM > OFM > input group (see optional feature).
- cfg_pend: set by CFG_Req, cleared in GRANT when CFG wins. CFG_Req coinciding with the clear re-sets cfg_pend (set wins).
- IF_Rdy low in IDLE: wait, no grant. IF_Rdy is ignored in GRANT/BUSY.
- IF_Val deassert mid-burst: burst continues to completion.
- Reset_X mid-burst of the same class: burst continues counting.
- Reset asserted: FSM to IDLE next edge, cnt 0, cfg_pend 0, IF_Req 0. IF_Cfg/IF_RdWr hold.
- Strobes arriving in IDLE/GRANT are not counted.

Optional Feature:
- ARB_RR_EN defined: round-robin among the four input buffers in order FLGWEI→WEI→FLGACT→ACT. The pointer advances to the entry after the winner on each input grant.
- Not defined: fixed priority FLGWEI > WEI > FLGACT > ACT, and no rr register is built.

Test Plan:
- Reset → IF_Req 0, IF_Cfg 0, IF_RdWr 1. Then IF_Val=1, IF_Rdy=1, all pointers 0 → single IF_Req with IF_Cfg=8, IF_RdWr=1 (FLGWEI free 31 ≥ 16). After 16 GBFFLGWEI_EnWr, ARB_Busy falls.
- CFG_Req pulse during a WEI burst → after the WEI burst completes (16 EnWr), next grant is IF_Cfg=0. It ends after 8 CFG_Val.
- GBFOFM_AddrWr=20, AddrRd=0, inputs all full → grant IF_Cfg=11, IF_RdWr=0. 16 GBFOFM_EnRd end it.
- GBFWEI_AddrWr=2, AddrRd=5 (wrap, occ=509, free=2), all others full → no grant. Move AddrRd to 20 → grant IF_Cfg=6.
- Reset asserted at cnt=7 of an ACT burst → ARB_Busy 0 next cycle. The next grant restarts with cnt 0.
- ARB_RR_EN defined, all inputs eligible repeatedly → grant codes 8, 6, 4, 2, 8. Without the macro → 8, 8, 8.

Source files
------------

// File: rtl/gbf_fill_arbiter.sv
// gbf_fill_arbiter
//
// Picks the next burst for the off-chip port. It watches the six global
// buffers (flag/weight, weight, flag/act, act, flag/ofm, ofm) and a pending
// config request. It issues a one-cycle IF_Req that carries the buffer code
// and direction. It re-arbitrates only after the granted burst has moved all
// of its words.
//
// Build option:
//   ARB_RR_EN  Defined: round-robin among the four input buffers.
//              Undefined: fixed priority FLGWEI > WEI > FLGACT > ACT.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   Reset                         sync clear: FSM idle, pending cfg and counter cleared
//   Reset_WEI/ACT/OFM             per-class pointer clear; masks the class for 2 cycles
//   IF_Val                        host link enabled; gates new grants
//   CFG_Req / CFG_Val             config request pulse / config word accepted
//   GBF*_AddrWr / GBF*_AddrRd     buffer write/read pointers
//   GBF*_EnWr / GBF*_EnRd         per-buffer word strobes (burst progress)
//   IF_Rdy                        interface can take a new request
//   IF_Req                        grant pulse
//   IF_Cfg                        buffer code: CFG 0, ACT 2, FLGACT 4, WEI 6,
//                                 FLGWEI 8, FLGOFM 10, OFM 11
//   IF_RdWr                       1 = host->chip, 0 = chip->host
//   ARB_Busy                      burst in progress
module gbf_fill_arbiter #(
    parameter int unsigned FLG_AW    = 5,
    parameter int unsigned DAT_AW    = 9,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CFG_LEN   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Reset,
    input  logic              Reset_WEI,
    input  logic              Reset_ACT,
    input  logic              Reset_OFM,
    input  logic              IF_Val,
    input  logic              CFG_Req,
    input  logic              CFG_Val,
    input  logic [FLG_AW-1:0] GBFFLGWEI_AddrWr,
    input  logic [FLG_AW-1:0] GBFFLGWEI_AddrRd,
    input  logic [FLG_AW-1:0] GBFFLGACT_AddrWr,
    input  logic [FLG_AW-1:0] GBFFLGACT_AddrRd,
    input  logic [FLG_AW-1:0] GBFFLGOFM_AddrWr,
    input  logic [FLG_AW-1:0] GBFFLGOFM_AddrRd,
    input  logic [DAT_AW-1:0] GBFWEI_AddrWr,
    input  logic [DAT_AW-1:0] GBFWEI_AddrRd,
    input  logic [DAT_AW-1:0] GBFACT_AddrWr,
    input  logic [DAT_AW-1:0] GBFACT_AddrRd,
    input  logic [DAT_AW-1:0] GBFOFM_AddrWr,
    input  logic [DAT_AW-1:0] GBFOFM_AddrRd,
    input  logic              GBFFLGWEI_EnWr,
    input  logic              GBFWEI_EnWr,
    input  logic              GBFFLGACT_EnWr,
    input  logic              GBFACT_EnWr,
    input  logic              GBFFLGOFM_EnRd,
    input  logic              GBFOFM_EnRd,
    input  logic              IF_Rdy,
    output logic              IF_Req,
    output logic [3:0]        IF_Cfg,
    output logic              IF_RdWr,
    output logic              ARB_Busy
);

    localparam logic [3:0] CODE_CFG    = 4'd0;
    localparam logic [3:0] CODE_ACT    = 4'd2;
    localparam logic [3:0] CODE_FLGACT = 4'd4;
    localparam logic [3:0] CODE_WEI    = 4'd6;
    localparam logic [3:0] CODE_FLGWEI = 4'd8;
    localparam logic [3:0] CODE_FLGOFM = 4'd10;
    localparam logic [3:0] CODE_OFM    = 4'd11;

    localparam int unsigned MAX_LEN = (BURST_LEN > CFG_LEN) ? BURST_LEN : CFG_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CFG_LAST   = CNT_W'(CFG_LEN - 1);
    localparam logic [FLG_AW-1:0] FLG_THR    = FLG_AW'(BURST_LEN);
    localparam logic [DAT_AW-1:0] DAT_THR    = DAT_AW'(BURST_LEN);
    localparam logic [FLG_AW-1:0] FLG_MAX    = '1;
    localparam logic [DAT_AW-1:0] DAT_MAX    = '1;

    typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cfg_pend_q;
    logic             rst_wei_q, rst_act_q, rst_ofm_q;

    // Occupancy at each buffer's own width; the subtraction wraps naturally.
    logic [FLG_AW-1:0] occ_flgwei, occ_flgact, occ_flgofm;
    logic [DAT_AW-1:0] occ_wei, occ_act, occ_ofm;

    assign occ_flgwei = GBFFLGWEI_AddrWr - GBFFLGWEI_AddrRd;
    assign occ_flgact = GBFFLGACT_AddrWr - GBFFLGACT_AddrRd;
    assign occ_flgofm = GBFFLGOFM_AddrWr - GBFFLGOFM_AddrRd;
    assign occ_wei    = GBFWEI_AddrWr - GBFWEI_AddrRd;
    assign occ_act    = GBFACT_AddrWr - GBFACT_AddrRd;
    assign occ_ofm    = GBFOFM_AddrWr - GBFOFM_AddrRd;

    // A class stays masked in the cycle its clear is seen and in the next one.
    logic blk_wei, blk_act, blk_ofm;
    assign blk_wei = Reset_WEI | rst_wei_q;
    assign blk_act = Reset_ACT | rst_act_q;
    assign blk_ofm = Reset_OFM | rst_ofm_q;

    // Input order: 0 FLGWEI, 1 WEI, 2 FLGACT, 3 ACT.
    logic [3:0] in_elig;
    logic       elig_flgofm, elig_ofm;

    assign in_elig[0]  = ((FLG_MAX - occ_flgwei) >= FLG_THR) && !blk_wei;
    assign in_elig[1]  = ((DAT_MAX - occ_wei) >= DAT_THR) && !blk_wei;
    assign in_elig[2]  = ((FLG_MAX - occ_flgact) >= FLG_THR) && !blk_act;
    assign in_elig[3]  = ((DAT_MAX - occ_act) >= DAT_THR) && !blk_act;
    assign elig_flgofm = (occ_flgofm >= FLG_THR) && !blk_ofm;
    assign elig_ofm    = (occ_ofm >= DAT_THR) && !blk_ofm;

    // Search start for the input group: rotating under round-robin, else FLGWEI.
    logic [1:0] rr_base;
`ifdef ARB_RR_EN
    logic [1:0] rr_q;
    assign rr_base = rr_q;
`else
    assign rr_base = 2'd0;
`endif

    logic       in_any;
    logic [1:0] in_sel;
    logic [3:0] in_code;

    always_comb begin
        in_any = 1'b0;
        in_sel = rr_base;
        for (int k = 0; k < 4; k++) begin
            if (!in_any && in_elig[rr_base + 2'(k)]) begin
                in_any = 1'b1;
                in_sel = rr_base + 2'(k);
            end
        end
    end

    always_comb begin
        unique case (in_sel)
            2'd0:    in_code = CODE_FLGWEI;
            2'd1:    in_code = CODE_WEI;
            2'd2:    in_code = CODE_FLGACT;
            default: in_code = CODE_ACT;
        endcase
    end

    // Winner: pending config, then outputs (flag first), then the input group.
    logic       win_any, win_rdwr, win_input;
    logic [3:0] win_code;

    always_comb begin
        win_any   = 1'b1;
        win_input = 1'b0;
        win_code  = CODE_CFG;
        win_rdwr  = 1'b1;
        if (cfg_pend_q) begin
            win_code = CODE_CFG;
        end else if (elig_flgofm) begin
            win_code = CODE_FLGOFM;
            win_rdwr = 1'b0;
        end else if (elig_ofm) begin
            win_code = CODE_OFM;
            win_rdwr = 1'b0;
        end else if (in_any) begin
            win_code  = in_code;
            win_input = 1'b1;
        end else begin
            win_any = 1'b0;
        end
    end

    // IF_Cfg holds the current winner, so it also selects the counted strobe.
    logic             strobe;
    logic [CNT_W-1:0] burst_last;

    always_comb begin
        case (IF_Cfg)
            CODE_CFG:    strobe = CFG_Val;
            CODE_ACT:    strobe = GBFACT_EnWr;
            CODE_FLGACT: strobe = GBFFLGACT_EnWr;
            CODE_WEI:    strobe = GBFWEI_EnWr;
            CODE_FLGWEI: strobe = GBFFLGWEI_EnWr;
            CODE_FLGOFM: strobe = GBFFLGOFM_EnRd;
            CODE_OFM:    strobe = GBFOFM_EnRd;
            default:     strobe = 1'b0;
        endcase
    end

    assign burst_last = (IF_Cfg == CODE_CFG) ? CFG_LAST : BURST_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cfg_pend_q <= 1'b0;
            rst_wei_q  <= 1'b0;
            rst_act_q  <= 1'b0;
            rst_ofm_q  <= 1'b0;
            IF_Req     <= 1'b0;
            IF_Cfg     <= CODE_CFG;
            IF_RdWr    <= 1'b1;
            ARB_Busy   <= 1'b0;
`ifdef ARB_RR_EN
            rr_q       <= 2'd0;
`endif
        end else begin
            rst_wei_q <= Reset_WEI;
            rst_act_q <= Reset_ACT;
            rst_ofm_q <= Reset_OFM;
            if (CFG_Req) begin
                cfg_pend_q <= 1'b1;
            end

            if (Reset) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                cfg_pend_q <= 1'b0;
                IF_Req     <= 1'b0;
                ARB_Busy   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (IF_Val && IF_Rdy && win_any) begin
                            state_q  <= StGrant;
                            cnt_q    <= '0;
                            IF_Req   <= 1'b1;
                            IF_Cfg   <= win_code;
                            IF_RdWr  <= win_rdwr;
                            ARB_Busy <= 1'b1;
`ifdef ARB_RR_EN
                            if (win_input) begin
                                rr_q <= in_sel + 2'd1;
                            end
`endif
                        end
                    end
                    StGrant: begin
                        state_q <= StBusy;
                        IF_Req  <= 1'b0;
                        // A new request in the same cycle keeps the pending flag set.
                        if (IF_Cfg == CODE_CFG) begin
                            cfg_pend_q <= CFG_Req;
                        end
                    end
                    StBusy: begin
                        if (strobe) begin
                            if (cnt_q == burst_last) begin
                                state_q  <= StIdle;
                                cnt_q    <= '0;
                                ARB_Busy <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifndef ARB_RR_EN
    // Only the round-robin build advances a pointer from the input winner.
    logic unused_win_input;
    assign unused_win_input = win_input;
`endif

endmodule
